// File: rtl/readout_pkg.sv
// Shared state encoding, word tags and CRC helper for the ADC frame capture path.
package readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_TRAILER = 2'd2,
    ST_DROP    = 2'd3
  } capture_state_t;

  localparam logic [7:0] HDR_TAG  = 8'hA5;
  localparam logic [3:0] DATA_TAG = 4'hD;
  localparam logic [7:0] TRL_TAG  = 8'h5A;

  // CRC-16-CCITT (poly 0x1021), one 16-bit word per call, MSB first.
  function automatic logic [15:0] crc16_ccitt_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    // NOTE: blocking assignments are right here: c is a local temporary, not a register.
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO with a free-word count; output is zero while empty.
module capture_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop;

  assign push     = wr_en && (count != (AW+1)'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign free     = (AW+1)'(DEPTH) - count;

  // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_capture.sv
// Frames each ADC read window as header + samples + trailer and streams it over AXI-Stream.
// Optional CRC trailer word enabled by defining CAPTURE_CRC_EN.
module adc_frame_capture
  import readout_pkg::*;
#(
  parameter int ADC_WIDTH   = 12,
  parameter int ADC_LATENCY = 8,
  parameter int TRIG_CNT_W  = 16,
  parameter int FIFO_DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic                  adc_valid,
  input  logic [ADC_WIDTH-1:0]  adc_data,
  input  logic [TRIG_CNT_W-1:0] trigger_count,
  input  logic                  clear_counters,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  overflow_sticky,
  output logic [15:0]           dropped_frames,
  output logic [15:0]           missed_trigs
);

  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

  capture_state_t         state;
  logic [ADC_LATENCY-1:0] en_sr;
  logic                   en_d, en_d_q, read_en_q;
  logic                   rise, en_fall, sample, can_write;
  logic                   drop_frame, drop_sample, missed_rise;
  logic [FREE_W-1:0]      free;
  logic                   wr_en;
  logic [32:0]            wr_data, rd_data;
  logic                   frame_ovf;
  logic [15:0]            sample_cnt;
`ifdef CAPTURE_CRC_EN
  logic [15:0]            crc;
  logic                   crc_phase;
`endif

  // Align read_en with the ADC pipeline so en_d brackets the valid samples.
  generate
    if (ADC_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) en_sr <= '0;
        else     en_sr <= read_en;
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (rst) en_sr <= '0;
        else     en_sr <= {en_sr[ADC_LATENCY-2:0], read_en};
      end
    end
  endgenerate

  assign en_d        = en_sr[ADC_LATENCY-1];
  assign rise        = read_en && !read_en_q;
  assign en_fall     = en_d_q && !en_d;
  assign sample      = en_d && adc_valid;
  // Three free words keep room for the trailer and optional CRC word at all times.
  assign can_write   = (free >= FREE_W'(3));
  assign drop_frame  = (state == ST_IDLE) && rise && !can_write;
  assign drop_sample = (state == ST_CAPTURE) && sample && !can_write;
  assign missed_rise = rise && (state != ST_IDLE);
  assign busy        = (state != ST_IDLE);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state)
      ST_IDLE: if (rise && can_write) begin
        wr_en   = 1'b1;
        wr_data = {1'b0, HDR_TAG, 8'h00, 16'(trigger_count)};
      end
      ST_CAPTURE: if (sample && can_write) begin
        wr_en   = 1'b1;
        wr_data = {1'b0, DATA_TAG, 4'h0, sample_cnt[11:0], 12'(adc_data)};
      end
      ST_TRAILER: begin
        wr_en = 1'b1;
`ifdef CAPTURE_CRC_EN
        wr_data = crc_phase ? {1'b1, 16'h0000, crc}
                            : {1'b0, TRL_TAG, frame_ovf, 7'b0, sample_cnt};
`else
        wr_data = {1'b1, TRL_TAG, frame_ovf, 7'b0, sample_cnt};
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      read_en_q  <= 1'b0;
      en_d_q     <= 1'b0;
      frame_ovf  <= 1'b0;
      sample_cnt <= '0;
`ifdef CAPTURE_CRC_EN
      crc        <= 16'hFFFF;
      crc_phase  <= 1'b0;
`endif
    end else begin
      read_en_q <= read_en;
      en_d_q    <= en_d;
      unique case (state)
        ST_IDLE: if (rise) begin
          if (can_write) begin
            state      <= ST_CAPTURE;
            frame_ovf  <= 1'b0;
            sample_cnt <= '0;
`ifdef CAPTURE_CRC_EN
            crc        <= 16'hFFFF;
`endif
          end else begin
            state <= ST_DROP;
          end
        end
        ST_CAPTURE: begin
          if (sample) begin
            if (can_write) begin
              sample_cnt <= sample_cnt + 16'd1;
`ifdef CAPTURE_CRC_EN
              crc        <= crc16_ccitt_step(crc, 16'(adc_data));
`endif
            end else begin
              frame_ovf <= 1'b1;
            end
          end
          if (en_fall) state <= ST_TRAILER;
        end
        ST_TRAILER: begin
`ifdef CAPTURE_CRC_EN
          if (crc_phase) begin
            crc_phase <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            crc_phase <= 1'b1;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_DROP: if (en_fall) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status counters saturate; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_frames  <= '0;
      missed_trigs    <= '0;
      overflow_sticky <= 1'b0;
    end else if (clear_counters) begin
      dropped_frames  <= '0;
      missed_trigs    <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      if (drop_frame && (dropped_frames != 16'hFFFF)) dropped_frames <= dropped_frames + 16'd1;
      if (missed_rise && (missed_trigs != 16'hFFFF))  missed_trigs   <= missed_trigs + 16'd1;
      if (drop_frame || drop_sample)                  overflow_sticky <= 1'b1;
    end
  end

  capture_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_valid (m_axis_tvalid),
    .rd_data  (rd_data),
    .rd_ready (m_axis_tready),
    .free     (free)
  );

  assign m_axis_tdata = rd_data[31:0];
  assign m_axis_tlast = rd_data[32];

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: default-depth and 64-word-depth instances share one clock.
module tb_adc_frame_capture;

`ifdef CAPTURE_CRC_EN
  localparam int CRC_WORDS = 1;
  localparam bit TRL_LAST  = 1'b0;
`else
  localparam int CRC_WORDS = 0;
  localparam bit TRL_LAST  = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_read_en, a_adc_valid, a_clear, a_tready;
  logic [11:0] a_adc_data;
  logic [15:0] a_trig;
  logic [31:0] a_tdata;
  logic        a_tvalid, a_tlast, a_busy, a_ovf;
  logic [15:0] a_dropped, a_missed;

  logic        b_read_en, b_adc_valid, b_clear, b_tready;
  logic [11:0] b_adc_data;
  logic [15:0] b_trig;
  logic [31:0] b_tdata;
  logic        b_tvalid, b_tlast, b_busy, b_ovf;
  logic [15:0] b_dropped, b_missed;

  adc_frame_capture dut_a (
    .clk(clk), .rst(rst), .read_en(a_read_en), .adc_valid(a_adc_valid), .adc_data(a_adc_data),
    .trigger_count(a_trig), .clear_counters(a_clear), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(a_tready), .m_axis_tlast(a_tlast), .busy(a_busy), .overflow_sticky(a_ovf),
    .dropped_frames(a_dropped), .missed_trigs(a_missed)
  );

  adc_frame_capture #(.FIFO_DEPTH(64)) dut_b (
    .clk(clk), .rst(rst), .read_en(b_read_en), .adc_valid(b_adc_valid), .adc_data(b_adc_data),
    .trigger_count(b_trig), .clear_counters(b_clear), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(b_tready), .m_axis_tlast(b_tlast), .busy(b_busy), .overflow_sticky(b_ovf),
    .dropped_frames(b_dropped), .missed_trigs(b_missed)
  );

  int errors = 0;
  int checks = 0;
  logic [32:0] q_a [$];
  logic [32:0] q_b [$];

  // Record every word the sink accepts; sampled mid-cycle, accepted on the following rising edge.
  always @(negedge clk) begin
    if (a_tvalid && a_tready) q_a.push_back({a_tlast, a_tdata});
    if (b_tvalid && b_tready) q_b.push_back({b_tlast, b_tdata});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-16-CCITT over one 16-bit word: fold the word in, then 16 shifts.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    for (int i = 0; i < 16; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic check_frame(input string tag, input logic [32:0] q [$], input logic [15:0] trig,
                             input int n, input int first_data, input bit ovf);
    int          bad;
    logic [15:0] crc;
    logic [11:0] d;
    logic [32:0] exp;
    check({tag, "_words"}, 64'(q.size()), 64'(n + 2 + CRC_WORDS));
    if (q.size() != n + 2 + CRC_WORDS) return;
    check({tag, "_hdr"}, 64'(q[0]), 64'({1'b0, 8'hA5, 8'h00, trig}));
    bad = 0;
    crc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      d   = 12'(first_data + i);
      exp = {1'b0, 4'hD, 4'h0, 12'(i), d};
      if (q[i+1] !== exp) bad++;
      crc = ref_crc(crc, {4'h0, d});
    end
    check({tag, "_data_bad_count"}, 64'(bad), 64'd0);
    check({tag, "_trl"}, 64'(q[n+1]), 64'({TRL_LAST, 8'h5A, ovf, 7'b0, 16'(n)}));
`ifdef CAPTURE_CRC_EN
    check({tag, "_crc"}, 64'(q[n+2]), 64'({1'b1, 16'h0000, crc}));
`endif
  endtask

  initial begin
    rst = 1'b1;
    {a_read_en, a_adc_valid, a_clear, a_tready, a_adc_data, a_trig} = '0;
    {b_read_en, b_adc_valid, b_clear, b_tready, b_adc_data, b_trig} = '0;
    repeat (3) tick;

    // Reset state
    check("rst_tvalid", 64'(a_tvalid), 64'd0);
    check("rst_tdata",  64'(a_tdata),  64'd0);
    check("rst_tlast",  64'(a_tlast),  64'd0);
    check("rst_busy",   64'(a_busy),   64'd0);
    check("rst_ovf",    64'(a_ovf),    64'd0);
    check("rst_cnts",   64'({a_dropped, a_missed}), 64'd0);
    rst = 1'b0;
    tick;

    // 1: 1280-sample window, sink always ready
    a_tready = 1'b1; a_trig = 16'd7; a_adc_valid = 1'b1;
    q_a.delete();
    for (int c = 0; c < 1300; c++) begin
      a_read_en  = (c < 1280);
      a_adc_data = 12'(c - 8);
      if (c == 0) check("t1_empty_before_hdr", 64'(a_tvalid), 64'd0);
      if (c == 1) begin
        check("t1_hdr_latency", 64'({a_tvalid, a_tdata}), 64'({1'b1, 32'hA5000007}));
        check("t1_busy", 64'(a_busy), 64'd1);
      end
      tick;
    end
    repeat (20) tick;
    check_frame("t1", q_a, 16'd7, 1280, 0, 1'b0);
    check("t1_ovf", 64'(a_ovf), 64'd0);
    check("t1_idle", 64'(a_busy), 64'd0);

    // 2: same window with the sink stalled until after the window
    q_a.delete();
    a_tready = 1'b0;
    for (int c = 0; c < 1300; c++) begin
      a_read_en  = (c < 1280);
      a_adc_data = 12'(c - 8);
      if (c >= 1) check("t2_stall_hold", 64'({a_tvalid, a_tlast, a_tdata}), 64'({2'b10, 32'hA5000007}));
      tick;
    end
    a_tready = 1'b1;
    repeat (1300) tick;
    check_frame("t2", q_a, 16'd7, 1280, 0, 1'b0);
    check("t2_ovf", 64'(a_ovf), 64'd0);

    // 3: 64-word FIFO, 100-sample window, sink stalled -> truncated frame
    b_tready = 1'b0; b_trig = 16'd3; b_adc_valid = 1'b1;
    q_b.delete();
    for (int c = 0; c < 130; c++) begin
      b_read_en  = (c < 100);
      b_adc_data = 12'(c - 8);
      tick;
    end
    check("t3_ovf_sticky", 64'(b_ovf), 64'd1);
    check("t3_idle", 64'(b_busy), 64'd0);

    // 4: FIFO still nearly full at the next rise -> frame dropped whole
    for (int c = 0; c < 40; c++) begin
      b_read_en  = (c < 10);
      b_adc_data = 12'(c);
      if (c == 1)  check("t4_drop_busy", 64'(b_busy), 64'd1);
      if (c == 25) check("t4_drop_idle", 64'(b_busy), 64'd0);
      tick;
    end
    check("t4_dropped", 64'(b_dropped), 64'd1);
    check("t4_missed",  64'(b_missed),  64'd0);
    b_tready = 1'b1;
    repeat (80) tick;
    check_frame("t3", q_b, 16'd3, 61, 0, 1'b1);

    // 5: second rise two cycles after the first window ends -> missed; samples 1..4
    q_a.delete();
    a_tready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      a_read_en  = (c < 4) || (c >= 6 && c < 10);
      a_trig     = (c < 5) ? 16'h0102 : 16'h0999;
      a_adc_data = 12'(c - 7);
      tick;
    end
    repeat (10) tick;
    check("t5_missed", 64'(a_missed), 64'd1);
    check_frame("t5", q_a, 16'h0102, 4, 1, 1'b0);

    // Clear pulse zeroes counters and the sticky flag
    a_clear = 1'b1; b_clear = 1'b1;
    tick;
    a_clear = 1'b0; b_clear = 1'b0;
    check("clr_missed",  64'(a_missed),  64'd0);
    check("clr_dropped", 64'(b_dropped), 64'd0);
    check("clr_sticky",  64'(b_ovf),     64'd0);
    tick;
    check("clr_hold", 64'({a_missed, b_dropped, b_ovf}), 64'd0);

    // 6: reset mid-frame discards everything, no trailer afterwards
    q_a.delete();
    a_tready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      a_read_en  = 1'b1;
      a_adc_data = 12'(c);
      tick;
    end
    check("t6_pre_rst_busy", 64'(a_busy), 64'd1);
    rst = 1'b1; a_read_en = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    check("t6_rst_tvalid", 64'(a_tvalid), 64'd0);
    check("t6_rst_busy",   64'(a_busy),   64'd0);
    a_tready = 1'b1;
    repeat (20) tick;
    check("t6_no_trailer", 64'(q_a.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
